// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed 32-bit multiply/divide unit
// Radix-2 Booth multiply and restoring magnitude divide, 32 iterations each; HI/LO held until next result.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [32:0] booth_sum;
  logic [64:0] booth_next;
  logic [32:0] rem_sh, trial;
  logic [31:0] rem_nx, quot_nx, rem_fin, quot_fin;

  // One Booth step: 33-bit add keeps the true sign before the arithmetic shift.
  always_comb begin
    booth_sum = {acc_q[64], acc_q[64:33]};
    case (acc_q[1:0])
      2'b01:   booth_sum = {acc_q[64], acc_q[64:33]} + {b_q[31], b_q};
      2'b10:   booth_sum = {acc_q[64], acc_q[64:33]} - {b_q[31], b_q};
      default: booth_sum = {acc_q[64], acc_q[64:33]};
    endcase
    booth_next = {booth_sum, acc_q[32:1]};
  end

  // One restoring-division step on magnitudes, plus final sign fix-up.
  always_comb begin
    rem_sh = {rem_q, quot_q[31]};
    trial  = rem_sh - {1'b0, b_q};
    if (trial[32]) begin
      rem_nx  = rem_sh[31:0];
      quot_nx = {quot_q[30:0], 1'b0};
    end else begin
      rem_nx  = trial[31:0];
      quot_nx = {quot_q[30:0], 1'b1};
    end
    quot_fin = (sign_a_q ^ sign_b_q) ? -quot_nx : quot_nx;
    rem_fin  = sign_a_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          acc_d   = {32'd0, op_a, 1'b0};
          b_d     = op_b;
          cnt_d   = 6'd0;
          dz_d    = 1'b0;
          state_d = S_MULT;
        end else if (start_div) begin
          sign_a_d = op_a[31];
          sign_b_d = op_b[31];
          rem_d    = 32'd0;
          quot_d   = op_a[31] ? -op_a : op_a;
          b_d      = op_b[31] ? -op_b : op_b;
          cnt_d    = 6'd0;
          dz_d     = (op_b == 32'd0);
          state_d  = (op_b == 32'd0) ? S_DONE : S_DIV;
        end
      end
      S_MULT: begin
        acc_d = booth_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = booth_next[64:33];
          lo_d    = booth_next[32:1];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        rem_d  = rem_nx;
        quot_d = quot_nx;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          hi_d    = rem_fin;
          lo_d    = quot_fin;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 65'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      quot_q   <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
// Expected HI/LO come from 64-bit signed arithmetic; timing from the documented cycle schedule.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  // Called at a negedge; returns at the negedge of the first idle cycle after the operation.
  task automatic run_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input string name);
    logic [31:0] old_hi, old_lo, e_hi, e_lo, x_hi, x_lo;
    logic        dz;
    longint      x, y, p;
    int          ia, ib, dc;
    old_hi = m_hi;
    old_lo = m_lo;
    ia = a;
    ib = b;
    x  = ia;
    y  = ib;
    dz = !sm && sd && (b == 32'd0);
    if (sm) begin
      p = x * y;
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (dz) begin
      e_hi = old_hi;
      e_lo = old_lo;
    end else begin
      p = x / y;
      e_lo = p[31:0];
      p = x % y;
      e_hi = p[31:0];
    end
    dc = dz ? 1 : 33;
    start_mult = sm;
    start_div  = sd;
    op_a = a;
    op_b = b;
    @(posedge clock);
    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clock);
      x_hi = (c >= dc) ? e_hi : old_hi;
      x_lo = (c >= dc) ? e_lo : old_lo;
      n_checks++;
      if ({busy, done, div_zero} !== {(c <= dc), (c == dc), (c == dc) && dz}) begin
        n_fail++;
        $display("FAIL %s ctrl cycle %0d: busy/done/div_zero=%b%b%b expected %b%b%b", name, c,
                 busy, done, div_zero, (c <= dc), (c == dc), (c == dc) && dz);
      end
      n_checks++;
      if (hi !== x_hi || lo !== x_lo) begin
        n_fail++;
        $display("FAIL %s result cycle %0d: hi=%h lo=%h expected hi=%h lo=%h", name, c, hi, lo, x_hi, x_lo);
      end
      if (c == 1) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      start_mult = (c == inj);
      start_div  = (c == inj);
    end
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_mult = 1'b0;
    start_div = 1'b0;
    op_a = 32'd0;
    op_b = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b div_zero=%b expected all 0", hi, lo, busy, done, div_zero);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 0, "mult_7x-3");
    run_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, "mult_maxpos");
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 0, "mult_maxneg");
  endtask

  task automatic test_div();
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 0, "div_-7/2");
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, "div_100/7");
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div_overflow");
    run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, "div_100/7_again");
  endtask

  task automatic test_div_zero();
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, "div_zero");
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++;
      $display("FAIL div_zero_hold: hi=%h lo=%h expected hi=00000002 lo=0000000e", hi, lo);
    end
  endtask

  task automatic test_collision();
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 10, "collision_busy_start");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          kind;
    run_op(1'b1, 1'b0, $urandom, $urandom, 33, "b2b_start_in_done");
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (kind == 3) begin
        a = $urandom_range(0, 200) - 100;
        b = $urandom_range(0, 20) - 10;
      end
      run_op(kind != 1, kind != 0, a, b, 0, "random");
    end
  endtask

  task automatic test_reset_mid();
    start_mult = 1'b1;
    op_a = 32'h00012345;
    op_b = 32'h00000777;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      start_mult = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    start_mult = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b div_zero=%b expected all 0", hi, lo, busy, done, div_zero);
    end
    reset = 1'b0;
    start_mult = 1'b0;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_dropped: busy=%b expected 0", busy);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_op(1'b1, 1'b0, 32'd6, 32'd5, 0, "mult_after_reset");
  endtask

  initial begin
    test_reset();
    @(negedge clock);
    test_mult();
    test_div();
    test_div_zero();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
